// File: rtl/lockstep_pkg.sv
// Shared types and parameter checks for the lockstep counter checker.
package lockstep_pkg;

  typedef enum logic [1:0] {
    MATCH   = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2
  } state_t;

  function automatic bit params_ok(
    int width,
    int channels,
    int tolerance,
    int mmw
  );
    return (width >= 2) && (channels >= 2) &&
           (tolerance >= 0) && (mmw >= 1);
  endfunction

endpackage

// File: rtl/lockstep_counter_checker_count_ch.sv
// One counter channel: synchronous clear beats enable, wraps silently.
module count_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/lockstep_counter_checker.sv
// N redundant counters cross-checked against channel 0 with a
// filtered sticky alarm, offender capture and mismatch statistics.
module lockstep_counter_checker
  import lockstep_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int TOLERANCE = 0,
  parameter int MMW       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [CHANNELS-1:0]           en,
  input  logic [CHANNELS-1:0]           clr,
  input  logic                          alarm_clr,
  output logic [CHANNELS*WIDTH-1:0]     cnt,
  output logic [CHANNELS-1:0]           diff,
  output logic                          diff_any,
  output logic                          alarm,
  output logic [$clog2(CHANNELS)-1:0]   first_ch,
  output logic [MMW-1:0]                mm_cycles
);

  localparam int CW = $clog2(CHANNELS);
  localparam int RW = $clog2(TOLERANCE + 2);

  if (!params_ok(WIDTH, CHANNELS, TOLERANCE, MMW)) begin : g_bad
    $error("lockstep_counter_checker: illegal parameters");
  end

  logic [WIDTH-1:0]    cnt_ch [CHANNELS];
  logic [CHANNELS-1:0] diff_next;
  logic [CW-1:0]       low_ch;
  state_t              state;
  state_t              state_n;
  logic [RW-1:0]       run;
  logic [RW-1:0]       run_n;
  logic                enter;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    count_ch #(
      .WIDTH (WIDTH)
    ) u_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (en[g]),
      .clr  (clr[g]),
      .cnt  (cnt_ch[g])
    );
    assign cnt[g*WIDTH +: WIDTH] = cnt_ch[g];
  end

  always_comb begin
    diff_next = '0;
    for (int i = 1; i < CHANNELS; i++) begin
      diff_next[i] = (cnt_ch[i] != cnt_ch[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      diff     <= '0;
      diff_any <= 1'b0;
    end else begin
      diff     <= diff_next;
      diff_any <= |diff_next;
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    unique case (state)
      MATCH: begin
        if (diff_any) begin
          if (TOLERANCE == 0) begin
            state_n = ALARM;
          end else begin
            state_n = PENDING;
            run_n   = RW'(1);
          end
        end
      end
      PENDING: begin
        if (!diff_any) begin
          state_n = MATCH;
          run_n   = '0;
        end else if ((int'(run) + 1) > TOLERANCE) begin
          state_n = ALARM;
        end else begin
          run_n = run + RW'(1);
        end
      end
      ALARM: begin
        // Clear wins; a persisting mismatch re-arms the filter.
        if (alarm_clr) begin
          state_n = MATCH;
          run_n   = '0;
        end
      end
      default: begin
        state_n = MATCH;
        run_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= MATCH;
      run   <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
    end
  end

  assign alarm = (state == ALARM);
  assign enter = (state != ALARM) && (state_n == ALARM);

  always_comb begin
    low_ch = '0;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      if (diff[i]) begin
        low_ch = CW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      first_ch  <= '0;
      mm_cycles <= '0;
    end else begin
      if (enter) begin
        first_ch <= low_ch;
      end
      if (diff_any && (mm_cycles != '1)) begin
        mm_cycles <= mm_cycles + MMW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lockstep_counter_checker.sv
// Directed and randomized checks of lockstep_counter_checker.
module tb_lockstep_counter_checker;

  localparam int W = 8;
  localparam int C = 3;
  localparam int T = 2;
  localparam int M = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn;
  logic [C-1:0]   en;
  logic [C-1:0]   clr;
  logic           alarm_clr;
  logic [C*W-1:0] cnt;
  logic [C-1:0]   diff;
  logic           diff_any;
  logic           alarm;
  logic [1:0]     first_ch;
  logic [M-1:0]   mm_cycles;

  lockstep_counter_checker #(
    .WIDTH     (W),
    .CHANNELS  (C),
    .TOLERANCE (T),
    .MMW       (M)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .clr       (clr),
    .alarm_clr (alarm_clr),
    .cnt       (cnt),
    .diff      (diff),
    .diff_any  (diff_any),
    .alarm     (alarm),
    .first_ch  (first_ch),
    .mm_cycles (mm_cycles)
  );

  logic        rstn_b;
  logic [1:0]  en_b;
  logic [1:0]  clr_b;
  logic        alarm_clr_b;
  logic [7:0]  cnt_b;
  logic [1:0]  diff_b;
  logic        diff_any_b;
  logic        alarm_b;
  logic [0:0]  first_ch_b;
  logic [15:0] mm_b;

  lockstep_counter_checker #(
    .WIDTH     (4),
    .CHANNELS  (2),
    .TOLERANCE (0),
    .MMW       (16)
  ) dut_b (
    .clk       (clk),
    .rstn      (rstn_b),
    .en        (en_b),
    .clr       (clr_b),
    .alarm_clr (alarm_clr_b),
    .cnt       (cnt_b),
    .diff      (diff_b),
    .diff_any  (diff_any_b),
    .alarm     (alarm_b),
    .first_ch  (first_ch_b),
    .mm_cycles (mm_b)
  );

  int checks = 0;
  int failures = 0;

  int         m_cnt [C];
  logic [C-1:0] m_diff = '0;
  logic       m_any = 1'b0;
  logic       m_alarm = 1'b0;
  int         m_first = 0;
  int         m_mm = 0;
  int         streak = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: alarm fires once the mismatch streak exceeds T cycles.
  task automatic model_edge();
    logic [C-1:0] nd;
    int lo;
    if (!rstn) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_diff = '0; m_any = 0; m_alarm = 0;
      m_first = 0; m_mm = 0; streak = 0;
    end else begin
      nd = '0;
      for (int i = 1; i < C; i++) nd[i] = (m_cnt[i] != m_cnt[0]);
      lo = 0;
      for (int i = C - 1; i >= 1; i--) if (m_diff[i]) lo = i;
      if (m_alarm) begin
        if (alarm_clr) begin
          m_alarm = 0;
          streak = 0;
        end
      end else if (m_any) begin
        streak++;
        if (streak > T) begin
          m_alarm = 1;
          m_first = lo;
        end
      end else begin
        streak = 0;
      end
      if (m_any && m_mm < (2 ** M) - 1) m_mm++;
      m_diff = nd;
      m_any = |nd;
      for (int i = 0; i < C; i++) begin
        if (clr[i]) m_cnt[i] = 0;
        else if (en[i]) m_cnt[i] = (m_cnt[i] + 1) % (2 ** W);
      end
    end
  endtask

  task automatic check_a();
    for (int i = 0; i < C; i++) chk($sformatf("cnt%0d", i), cnt[i*W +: W], m_cnt[i]);
    chk("diff", diff, m_diff);
    chk("diff_any", diff_any, m_any);
    chk("alarm", alarm, m_alarm);
    chk("first_ch", first_ch, m_first);
    chk("mm_cycles", mm_cycles, m_mm);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_a();
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    rstn = 0; en = '0; clr = '0; alarm_clr = 0;
    rstn_b = 0; en_b = '0; clr_b = '0; alarm_clr_b = 0;
    step();
    step();
    chk("reset_alarm", alarm, 0);
    chk("reset_cnt", cnt, 0);

    rstn = 1; en = '1;
    repeat (100) step();
    for (int i = 0; i < C; i++) chk("lock100", cnt[i*W +: W], 100);
    chk("lock_diff", diff, 0);
    chk("lock_mm", mm_cycles, 0);

    en = 3'b011; step();
    en = '1; clr = '1; step();
    chk("glitch_diff", diff, 3'b100);
    clr = '0; en = '0; step();
    chk("glitch_diff_gone", diff, 0);
    chk("glitch_mm", mm_cycles, 1);
    chk("glitch_alarm", alarm, 0);

    rstn = 0; step(); rstn = 1; en = '1;
    repeat (50) step();
    clr = 3'b010; step();
    clr = '0; step();
    chk("persist_diff", diff, 3'b010);
    step(); step();
    chk("persist_e3", alarm, 0);
    step();
    chk("persist_e4", alarm, 1);
    chk("persist_first", first_ch, 1);

    alarm_clr = 1; step(); alarm_clr = 0;
    chk("aclr_low0", alarm, 0);
    step(); chk("aclr_low1", alarm, 0);
    step(); chk("aclr_low2", alarm, 0);
    step(); chk("aclr_rearm", alarm, 1);

    clr = '1; step(); clr = '0;
    step(); step();
    alarm_clr = 1; step(); alarm_clr = 0;
    chk("realign_clear", alarm, 0);
    repeat (5) step();
    chk("realign_stay", alarm, 0);
    chk("realign_first", first_ch, 1);

    rstn = 0; step(); rstn = 1;
    repeat (50) step();
    clr = 3'b110; step(); clr = '0;
    repeat (4) step();
    chk("multi_alarm", alarm, 1);
    chk("multi_first", first_ch, 1);

    rstn = 0; step(); rstn = 1;
    chk("rst_alarm", {alarm, first_ch, diff, diff_any}, 0);
    chk("rst_mm", mm_cycles, 0);

    en = 3'b011;
    repeat (22) step();
    chk("sat_mm", mm_cycles, 15);
    en = '1;

    repeat (400) begin
      int r;
      r = int'($urandom_range(0, 19));
      en = ($urandom_range(0, 5) == 0) ? 3'($urandom) : '1;
      clr = (r == 0) ? '1 : (r == 1) ? 3'($urandom) : '0;
      alarm_clr = ($urandom_range(0, 11) == 0);
      rstn = ($urandom_range(0, 149) != 0);
      step();
    end
    rstn = 1; clr = '0; alarm_clr = 0;

    step();
    rstn_b = 1; en_b = 2'b11;
    repeat (17) step();
    chk("wrap_cnt", cnt_b, 8'h11);
    chk("wrap_diff", diff_b, 0);
    chk("wrap_alarm", alarm_b, 0);
    en_b = 2'b01; step();
    en_b = 2'b11; step();
    chk("t0_diff", diff_b, 2'b10);
    chk("t0_e1", alarm_b, 0);
    step();
    chk("t0_e2", alarm_b, 1);
    chk("t0_first", first_ch_b, 1);
    chk("t0_mm", mm_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
